// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter
//   Round-robin arbiter and select sequencer for a shared 8:1 mux.
//   Picks one active requester per grant period and drives the mux select.
//   Caps how long a requester may hold the mux while others are waiting.
//   Gates the routed data bit with the grant-active flag.
//
// Ports
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   en    : arbitration enable; low releases any grant
//   req   : request per source, bit i = source i
//   in    : data bit per source, routed when that source is granted
//   sel   : registered mux select (index of current grantee)
//   grant : registered one-hot grant, zero when idle
//   valid : registered, high while a grant is active
//   out   : in[sel] AND valid (combinational)
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic [7:0] in,
  output logic [2:0] sel,
  output logic [7:0] grant,
  output logic       valid,
  output logic       out
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [HOLD_W-1:0] HOLD_MAX_C = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE_C = HOLD_W'(1);

  state_t            state_r;
  logic [2:0]        last_r;
  logic [HOLD_W-1:0] hold_cnt_r;

  logic [7:0]        start_mask_s;
  logic [3:0]        pick_all_s;   // {found, index} over every request
  logic [3:0]        pick_oth_s;   // {found, index} excluding the current grantee
  logic [2:0]        start_s;

  // Round-robin search: first set bit of mask scanning start, start+1, ... wrapping 7->0.
  // Iterating from the farthest offset down lets the nearest hit overwrite the result.
  function automatic logic [3:0] rr_pick(input logic [7:0] mask, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int k = 7; k >= 0; k--) begin
      idx = start + 3'(k);
      if (mask[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

  // Candidate selection for the next grant, searched from the source after the last grantee.
  always_comb begin
    start_s      = last_r + 3'd1;
    start_mask_s = req & ~grant;
    pick_all_s   = rr_pick(req, start_s);
    pick_oth_s   = rr_pick(start_mask_s, start_s);
  end

  // Arbitration state, grant registers and hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      sel        <= 3'd0;
      grant      <= 8'h00;
      valid      <= 1'b0;
      last_r     <= 3'd7;
      hold_cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (en && pick_all_s[3]) begin
            sel        <= pick_all_s[2:0];
            grant      <= onehot8(pick_all_s[2:0]);
            valid      <= 1'b1;
            last_r     <= pick_all_s[2:0];
            hold_cnt_r <= HOLD_ONE_C;
            state_r    <= GRANT;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT: begin
          if (!en) begin
            // sel and last are deliberately kept so fairness resumes where it left off
            grant   <= 8'h00;
            valid   <= 1'b0;
            state_r <= IDLE;
          end else if (!req[sel] || (hold_cnt_r >= HOLD_MAX_C)) begin
            if (pick_oth_s[3]) begin
              // release or hold expiry with someone waiting: hand over in the same edge
              sel        <= pick_oth_s[2:0];
              grant      <= onehot8(pick_oth_s[2:0]);
              last_r     <= pick_oth_s[2:0];
              hold_cnt_r <= HOLD_ONE_C;
            end else if (!req[sel]) begin
              grant   <= 8'h00;
              valid   <= 1'b0;
              state_r <= IDLE;
            end else begin
              // sole requester past its hold limit keeps the mux, counter saturates
              hold_cnt_r <= HOLD_MAX_C;
            end
          end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_ONE_C;
          end
        end
        default: begin
          state_r <= IDLE;
          grant   <= 8'h00;
          valid   <= 1'b0;
        end
      endcase
    end
  end

  assign out = in[sel] & valid;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
module tb_mux8_rr_arbiter;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] in_v;

  logic [2:0] sel4, sel1;
  logic [7:0] grant4, grant1;
  logic       valid4, valid1;
  logic       out4, out1;

  int errors = 0;
  int checks = 0;

  mux8_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .req(req), .in(in_v),
    .sel(sel4), .grant(grant4), .valid(valid4), .out(out4)
  );

  mux8_rr_arbiter #(.MAX_HOLD(1), .HOLD_W(4)) dut1 (
    .clk(clk), .rst(rst), .en(en), .req(req), .in(in_v),
    .sel(sel1), .grant(grant1), .valid(valid1), .out(out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // check all four dut4 outputs at once
  task automatic expect4(input string tag, input logic [7:0] g, input logic [2:0] s,
                         input logic v, input logic o);
    check({tag, ".grant"}, grant4, g);
    check({tag, ".sel"}, {5'd0, sel4}, {5'd0, s});
    check({tag, ".valid"}, {7'd0, valid4}, {7'd0, v});
    check({tag, ".out"}, {7'd0, out4}, {7'd0, o});
  endtask

  initial begin
    logic [7:0] rout;
    int e;
    rout = 8'b1100_1100;

    // reset held for two edges with every source requesting
    rst = 1'b1; en = 1'b1; req = 8'hFF; in_v = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      expect4("reset", 8'h00, 3'd0, 1'b0, 1'b0);
      check("reset.out1", {7'd0, out1}, 8'h00);
    end

    // full contention: MAX_HOLD=4 steps every 4 edges, MAX_HOLD=1 every edge
    rst = 1'b0; in_v = rout;
    for (int i = 0; i < 33; i++) begin
      tick();
      e = (i / 4) % 8;
      expect4("rot4", 8'h01 << e, 3'(e), 1'b1, rout[e]);
      check("rot1.sel", {5'd0, sel1}, 8'(i % 8));
      check("rot1.out", {7'd0, out1}, {7'd0, rout[i % 8]});
    end

    // single requester takes over one edge later and holds
    req = 8'b0000_1000; in_v = 8'b1010_1010;
    for (int i = 0; i < 7; i++) begin
      tick();
      expect4("single", 8'b0000_1000, 3'd3, 1'b1, 1'b1);
    end
    // saturated hold counter: a new requester wins on the very next edge
    req = 8'b0000_1001;
    tick();
    expect4("sat_rotate", 8'b0000_0001, 3'd0, 1'b1, 1'b0);

    // drop everything -> idle
    req = 8'h00;
    tick();
    expect4("idle0", 8'h00, 3'd0, 1'b0, 1'b0);

    // grant on 2, add 5 pending, then release 2
    req = 8'b0000_0100;
    tick();
    expect4("g2", 8'b0000_0100, 3'd2, 1'b1, 1'b0);
    req = 8'b0010_0100;
    tick();
    expect4("g2_hold", 8'b0000_0100, 3'd2, 1'b1, 1'b0);
    req = 8'b0010_0000;
    tick();
    expect4("handoff5", 8'b0010_0000, 3'd5, 1'b1, 1'b1);
    req = 8'h00;
    tick();
    expect4("release", 8'h00, 3'd5, 1'b0, 1'b0);

    // enable drop mid-grant keeps last, then reset mid-grant
    req = 8'b0100_0000;
    tick();
    expect4("g6", 8'b0100_0000, 3'd6, 1'b1, 1'b0);
    en = 1'b0;
    tick();
    expect4("en_off", 8'h00, 3'd6, 1'b0, 1'b0);
    en = 1'b1; req = 8'b1100_0001;
    tick();
    expect4("g7", 8'b1000_0000, 3'd7, 1'b1, 1'b1);
    rst = 1'b1;
    tick();
    expect4("rst_mid", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0; req = 8'hFF;
    tick();
    expect4("post_rst", 8'h01, 3'd0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
Round-robin arbiter and select sequencer that shares one 8:1 multiplexer between 8 requesters. It picks one active requester per grant period and drives the mux select. It bounds how long one requester may hold the mux, and it presents the selected data bit as a gated output. It sits in front of the existing 8:1 mux datapath and replaces a hand-driven sel.

Parameters:
MAX_HOLD, 4, maximum consecutive cycles a grant is held while another request is pending (1..15)
HOLD_W, 4, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
en  input  1  arbitration enable; low releases any grant
req  input  8  request per source; bit i = source i
in  input  8  data bit per source; bit i routed when source i is granted
sel  output  3  registered mux select, the index of the current grantee
grant  output  8  registered one-hot grant; all zero when idle
valid  output  1  registered; 1 while a grant is active
out  output  1  combinational in[sel] AND valid

Behaviour:
- The only clock is clk. rst is synchronous and active-high and is sampled on the rising edge of clk.
- Reset values: sel=0, grant=0, valid=0, out=0, state=IDLE, hold_cnt=0, last=7 (the first search starts at source 0).
- State IDLE:
  - If en=1 and req!=0: select the first set req bit scanning (last+1) mod 8 upward, wrapping 7->0.
  - At the next edge: grant=onehot(idx), sel=idx, valid=1, last=idx, hold_cnt=1, state=GRANT.
  - Latency from req to grant is one cycle.
- State GRANT, evaluated each edge in this priority order:
  1. en=0: grant=0, valid=0, state=IDLE. sel and last are retained.
  2. req[sel]=0 (grantee released), other requests present: re-arbitrate from (last+1) in the same edge with no idle bubble. The new grantee gets hold_cnt=1.
  3. req[sel]=0, no other request: grant=0, valid=0, state=IDLE.
  4. req[sel]=1, hold_cnt>=MAX_HOLD, another req bit set: rotate to the next requester from (last+1); hold_cnt=1.
  5. req[sel]=1, hold_cnt>=MAX_HOLD, no other request: keep the grant; hold_cnt saturates at MAX_HOLD.
  6. Otherwise: keep the grant; hold_cnt++.
- The rotation search excludes the current grantee except when it is the only requester (case 5).
- grant is always one-hot or zero. When grant!=0, sel equals the index of its set bit.
- out follows in[sel] combinationally while valid=1. out is 0 when valid=0.
- Reset mid-grant: the next edge applies reset values regardless of req or en.
- Requests asserted and deasserted within the same cycle between edges are not seen; the block acts only on edge-sampled values.
- MAX_HOLD=1: the grant rotates every cycle among all active requesters.

Test Plan:
- Reset: rst=1 for 2 cycles with req=8'hFF, en=1 -> grant=0, sel=0, valid=0, out=0 throughout; the first grant after rst falls goes to source 0.
- Single requester: req=8'b00001000, in=8'b10101010, en=1 -> one edge later grant=8'b00001000, sel=3, valid=1, out=1; the grant holds indefinitely with hold_cnt saturated at 4.
- Full contention: req=8'hFF, MAX_HOLD=4 -> sel sequence 0,0,0,0,1,1,1,1,...,7,7,7,7,0. This checks wrap-around and fairness.
- Handoff without bubble: grant on 2 with req[5] pending, then drop req[2] -> next edge grant=8'b00100000, sel=5, valid stays 1. Then drop all req -> next edge valid=0, out=0, grant=0.
- Enable and reset mid-grant:
  - Grant on 6, drive en=0 -> next edge grant=0, valid=0.
  - Restore en=1 with req=8'b11000001 -> grant goes to 7 (last=6 retained).
  - Assert rst during that grant -> next edge all reset values.
- Data routing: req=8'hFF, MAX_HOLD=1, in=8'b11001100 -> out follows 0,0,1,1,0,0,1,1 as sel steps 0..7.
